// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source feeding bit-serial detectors; first bit one cycle after accept, gapless back-to-back.
// Optional trailing parity bit when SERIAL_BIT_SOURCE_PARITY_EN is defined (ODD_PARITY selects sense).
module serial_bit_source #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_strobe,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             head;
  logic             accept;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  logic             parity;
`endif

  assign head = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  assign last_bit = (state == PARITY);
  assign bit_out  = (state == SHIFT) ? head : ((state == PARITY) ? parity : 1'b0);
`else
  assign last_bit = (state == SHIFT) && (cnt == '0);
  assign bit_out  = (state == SHIFT) ? head : 1'b0;
`endif

  assign bit_valid  = (state != IDLE);
  assign busy       = (state != IDLE);
  assign bit_strobe = bit_valid & bit_en;
  // Ready while idle or while the final bit is being consumed, so words chain without a gap.
  assign data_ready = rst_n & ((state == IDLE) | (last_bit & bit_en));
  assign accept     = data_valid & data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (accept) begin
      state  <= SHIFT;
      shreg  <= data_in;
      cnt    <= CW'(WIDTH - 1);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      parity <= (^data_in) ^ ODD_PARITY;
`endif
    end else if (bit_en) begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
            else           shreg <= {1'b0, shreg[WIDTH-1:1]};
          end else begin
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        PARITY:  state <= IDLE;
`endif
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: an MSB-first and an LSB-first instance checked against per-cycle bit queues.
module tb_serial_bit_source;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         bit_en;
  logic         dv  [2];
  logic         rdy [2];
  logic         bo  [2];
  logic         bv  [2];
  logic         bs  [2];
  logic         lb  [2];
  logic         bsy [2];

  bit q [2][$];
  int vectors = 0;
  int errors  = 0;
  int accepts = 0;

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv[0]), .data_ready(rdy[0]),
    .bit_en(bit_en), .bit_out(bo[0]), .bit_valid(bv[0]), .bit_strobe(bs[0]),
    .last_bit(lb[0]), .busy(bsy[0]));

  serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .ODD_PARITY(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv[1]), .data_ready(rdy[1]),
    .bit_en(bit_en), .bit_out(bo[1]), .bit_valid(bv[1]), .bit_strobe(bs[1]),
    .last_bit(lb[1]), .busy(bsy[1]));

  function automatic void push_word(int i, logic [W-1:0] w);
    for (int k = 0; k < W; k++) q[i].push_back((i == 0) ? w[W-1-k] : w[k]);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    q[i].push_back((^w) ^ (i == 1));
`endif
  endfunction

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, i, obs, exp);
    end
  endtask

  // Compare one instance against its queue, then retire/queue bits for the coming edge.
  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      int   n;
      logic rdy_exp;
      n       = q[i].size();
      rdy_exp = rst_n && ((n == 0) || ((n == 1) && bit_en));
      chk("bit_valid", i, bv[i], n != 0);
      chk("busy", i, bsy[i], n != 0);
      chk("data_ready", i, rdy[i], rdy_exp);
      chk("bit_strobe", i, bs[i], (n != 0) && bit_en);
      chk("last_bit", i, lb[i], n == 1);
      if (n != 0) begin
        chk("bit_out", i, bo[i], q[i][0]);
        if (bit_en) void'(q[i].pop_front());
      end else begin
        chk("bit_out_idle", i, bo[i], 1'b0);
      end
      if (dv[i] && rdy_exp) begin
        push_word(i, din);
        if (i == 0) accepts++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    din   = w;
    dv[0] = 1'b1;
    dv[1] = 1'b1;
    step();
    dv[0] = 1'b0;
    dv[1] = 1'b0;
  endtask

  initial begin
    int base;
    rst_n  = 1'b0;
    din    = '0;
    bit_en = 1'b1;
    dv[0]  = 1'b0;
    dv[1]  = 1'b0;
    #2;
    check_cycle();
    repeat (2) step();
    rst_n = 1'b1;

    // Single word, continuous pacing.
    send(8'hB4);
    repeat (12) step();

    // Two words offered back to back must stream without a gap.
    base  = accepts;
    din   = 8'hB0;
    dv[0] = 1'b1;
    dv[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (accepts == base + 1) din = 8'h0B;
      if (accepts >= base + 2) begin
        dv[0] = 1'b0;
        dv[1] = 1'b0;
      end
      step();
    end
    chk("two_accepts", 0, accepts == base + 2, 1'b1);
    dv[0] = 1'b0;
    dv[1] = 1'b0;

    // Half-rate pacing holds each bit two cycles.
    send(8'hB4);
    for (int c = 0; c < 20; c++) begin
      bit_en = (c % 2 == 0);
      step();
    end
    bit_en = 1'b1;
    repeat (4) step();

    // Asynchronous reset in the middle of a word.
    send(8'hFF);
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    q[0].delete();
    q[1].delete();
    check_cycle();
    repeat (2) step();
    rst_n = 1'b1;
    send(8'h80);
    repeat (12) step();

    send(8'h0D);
    repeat (12) step();

    chk("drained", 0, q[0].size() == 0, 1'b1);
    chk("drained", 1, q[1].size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
